// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV64 M-extension multiply/divide unit.
//
// Takes one operation over a valid/ready handshake. The operation runs on
// operand magnitudes: a shift-add multiply or a restoring divide, retiring
// STEP bits per cycle. The sign is corrected on the final edge. The result
// is returned over a second valid/ready handshake.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   flush     synchronous kill of any in-flight or held operation
//   in_valid  operation offered            in_ready  unit can accept
//   op        RISC-V funct3                is_word   W-variant (low 32 bits)
//   srca      rs1 operand                  srcb      rs2 operand
//   out_valid result available             out_ready consumer takes result
//   result    final result                 busy      unit not idle
//
// state | meaning
// IDLE  | waiting for an operation; in_ready high unless flushing
// BUSY  | iterating; counter holds the remaining STEP-bit chunks
// DONE  | result registered and held until out_valid && out_ready

module muldiv_iter #(
  parameter int XLEN = 64,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN / STEP + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(XLEN / STEP);
  localparam logic [CW-1:0] CNT_WORD = CW'(32 / STEP);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} stateE;

  stateE             state;
  logic [CW-1:0]     cnt;
  logic [2:0]        opReg;
  logic              wordReg;
  logic              negRes;
  logic              negRem;
  logic [2*XLEN-1:0] accP;
  logic [2*XLEN-1:0] mcReg;
  logic [XLEN-1:0]   mlReg;
  logic [XLEN:0]     remReg;
  logic [XLEN-1:0]   quoReg;
  logic [XLEN-1:0]   divisor;
  logic [XLEN-1:0]   resultReg;
  logic              outValidReg;

  function automatic logic [XLEN-1:0] wordExt(input logic isW, input logic [XLEN-1:0] x);
    if (isW) return XLEN'($signed(x[31:0]));
    return x;
  endfunction

  logic            wordMode;
  logic [2:0]      effOp;
  logic            signedA, signedB, negA, negB;
  logic [XLEN-1:0] aExt, bExt, magA, magB, minVal, specialRes;
  logic            divZero, overflow;

  // Operand preparation on the offered inputs. W-form MULH* collapse to MULW,
  // because only the low 32 bits of the product are ever kept.
  always_comb begin
    wordMode = (XLEN == 64) && is_word;
    effOp = op;
    if (wordMode && !op[2]) effOp = 3'b000;
    signedA = !(effOp == 3'b011 || effOp == 3'b101 || effOp == 3'b111);
    signedB = signedA && (effOp != 3'b010);
    aExt = srca;
    bExt = srcb;
    if (wordMode) begin
      aExt = signedA ? XLEN'($signed(srca[31:0])) : XLEN'(srca[31:0]);
      bExt = signedB ? XLEN'($signed(srcb[31:0])) : XLEN'(srcb[31:0]);
    end
    negA = signedA && aExt[XLEN-1];
    negB = signedB && bExt[XLEN-1];
    magA = negA ? -aExt : aExt;
    magB = negB ? -bExt : bExt;
    minVal = wordMode ? ({XLEN{1'b1}} << 31) : ({XLEN{1'b1}} << (XLEN - 1));
    divZero = effOp[2] && (bExt == '0);
    overflow = (effOp == 3'b100 || effOp == 3'b110) && (aExt == minVal) && (bExt == '1);
    if (divZero) specialRes = effOp[1] ? aExt : '1;
    else         specialRes = effOp[1] ? '0 : aExt;
  end

  logic [2*XLEN-1:0] pNext, mcNext, prodS;
  logic [XLEN-1:0]   mlNext, qNext, quoS, remS, rawRes, finalRes;
  logic [XLEN:0]     rNext;

  // STEP iterations of both datapaths per cycle. Only the datapath selected
  // by opReg contributes to the result.
  always_comb begin
    pNext  = accP;
    mcNext = mcReg;
    mlNext = mlReg;
    rNext  = remReg;
    qNext  = quoReg;
    for (int i = 0; i < STEP; i++) begin
      if (mlNext[0]) pNext = pNext + mcNext;
      mcNext = mcNext << 1;
      mlNext = mlNext >> 1;
      rNext = {rNext[XLEN-1:0], qNext[XLEN-1]};
      qNext = qNext << 1;
      if (rNext >= {1'b0, divisor}) begin
        rNext = rNext - {1'b0, divisor};
        qNext[0] = 1'b1;
      end
    end
    prodS = negRes ? -pNext : pNext;
    quoS  = negRes ? -qNext : qNext;
    remS  = negRem ? -rNext[XLEN-1:0] : rNext[XLEN-1:0];
    case (opReg)
      3'b000:                 rawRes = prodS[XLEN-1:0];
      3'b001, 3'b010, 3'b011: rawRes = prodS[2*XLEN-1:XLEN];
      3'b100, 3'b101:         rawRes = quoS;
      default:                rawRes = remS;
    endcase
    finalRes = wordExt(wordReg, rawRes);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      opReg       <= '0;
      wordReg     <= 1'b0;
      negRes      <= 1'b0;
      negRem      <= 1'b0;
      accP        <= '0;
      mcReg       <= '0;
      mlReg       <= '0;
      remReg      <= '0;
      quoReg      <= '0;
      divisor     <= '0;
      resultReg   <= '0;
      outValidReg <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      cnt         <= '0;
      outValidReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opReg   <= effOp;
            wordReg <= wordMode;
            negRes  <= negA ^ negB;
            negRem  <= negA;
            accP    <= '0;
            mcReg   <= {{XLEN{1'b0}}, magA};
            mlReg   <= magB;
            remReg  <= '0;
            // Word dividends are top-aligned so that 32 steps consume them fully.
            quoReg  <= wordMode ? (magA << (XLEN - 32)) : magA;
            divisor <= magB;
            if (divZero || overflow) begin
              resultReg   <= wordExt(wordMode, specialRes);
              outValidReg <= 1'b1;
              cnt         <= '0;
              state       <= DONE;
            end else begin
              cnt   <= wordMode ? CNT_WORD : CNT_FULL;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          accP   <= pNext;
          mcReg  <= mcNext;
          mlReg  <= mlNext;
          remReg <= rNext;
          quoReg <= qNext;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            resultReg   <= finalRes;
            outValidReg <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValidReg <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !flush;
  assign busy      = (state != IDLE);
  assign out_valid = outValidReg;
  assign result    = resultReg;

endmodule
